imem_access_arbiter: RTL
========================

// Module: imem_access_arbiter
// PURPOSE
//  Sequences every access to the 8K x 32 instruction memory and shares its single port between two requesters.
//  - Fetch: read-only, high priority.
//  - Loader: program load / debug, read or write.
//  Sits between the fetch stage / loader and the instruction memory. Drives its address, read/write enables and write data.
//  Registers the returned word back to the requester that issued the access.
// PARAMETERS
//  ADDR_W     13  word-address width (8192 words); zero-extended to 32 bits on mem_address
//  MEM_LAT    1   cycles from read-enable assertion to valid mem_dataOut (>=1)
//  STARVE_MAX 4   consecutive fetch grants, made while l_req is pending, before the loader is forced a grant (>=1)
// PORTS
//  clk              in   1       single clock, rising edge
//  rst_n            in   1       asynchronous, active-low reset
//  f_req            in   1       fetch read request; hold until f_done
//  f_addr           in   ADDR_W  fetch word address
//  f_rdata          out  32      fetch read data; valid while f_done=1, held afterwards
//  f_done           out  1       one-cycle completion pulse for fetch
//  l_req            in   1       loader request; hold until l_done
//  l_we             in   1       1 = write, 0 = read
//  l_addr           in   ADDR_W  loader word address
//  l_wdata          in   32      loader write data
//  l_rdata          out  32      loader read data; valid while l_done=1, held afterwards
//  l_done           out  1       one-cycle completion pulse for loader
//  mem_address      out  32      {0, granted addr}
//  mem_readEnable   out  1       memory read enable
//  mem_writeEnable  out  1       memory write enable
//  mem_dataIn       out  32      memory write data
//  mem_dataOut      in   32      memory read data
//  busy             out  1       1 whenever state != IDLE
// BEHAVIOUR
//  - Reset (async, rst_n=0): every output is 0, state=IDLE, starve_cnt=0.
//    An in-flight access is dropped with no done pulse. A request still held is accepted on the first edge after release.
//  - All outputs are registered. FSM states: IDLE, READ, WRITE, DONE.
//  - IDLE: requests are sampled only here. Let E0 be the accepting edge.
//    - f_req only: grant fetch.
//    - l_req only: grant loader.
//    - Both, starve_cnt < STARVE_MAX: grant fetch; starve_cnt++.
//    - Both, starve_cnt == STARVE_MAX: grant loader.
//    - Any loader grant clears starve_cnt. A fetch grant with l_req=0 leaves it unchanged.
//  - READ:
//    - mem_readEnable=1 and mem_address stable from E0 to E0+MEM_LAT.
//    - At E0+MEM_LAT: mem_dataOut is captured into the grantee's rdata, enables drop, grantee's done=1, state=DONE.
//  - WRITE (loader only, l_we=1 at E0):
//    - mem_writeEnable=1 with mem_address and mem_dataIn for exactly one cycle.
//    - At E0+1: enables drop, l_done=1, state=DONE.
//  - DONE: the done pulse lasts one cycle; always -> IDLE. A requester deasserts req at the edge it samples done=1.
//  - Throughput: one read per MEM_LAT+2 cycles, one write per 3 cycles.
//  - mem_readEnable and mem_writeEnable are never high together. Never more than one access is outstanding.
//  - addr/we/wdata are latched at E0. Requester changes after E0 are ignored until the next grant.
//  - rdata of the non-granted requester is never disturbed.
// CONFIGURATION
//  IMEM_ARB_WPROT_EN defined:
//    - Adds input wp_lock (1) and output l_err (1, reset 0).
//    - Loader write accepted while wp_lock=1: no mem_writeEnable. At E0+1, l_done=1 and l_err=1 for one cycle, state=DONE.
//    - l_err is 0 on every other completion. Reads are unaffected.
//  IMEM_ARB_WPROT_EN undefined: no wp_lock/l_err ports; all loader writes are issued.
// TESTING
//  1 Reset: rst_n=0 mid-READ -> all outputs 0 immediately, no done pulse; f_req held -> accepted first edge after release.
//  2 Fetch read: memory word 2 preloaded 32'h00221802, f_req, f_addr=2, MEM_LAT=1 -> mem_address=2, f_rdata=32'h00221802, f_done 2 cycles after request.
//  3 Loader write then read: write 32'hDEADBEEF to addr 100 -> one-cycle mem_writeEnable; read addr 100 -> l_rdata=32'hDEADBEEF.
//  4 Contention: f_req and l_req both held, STARVE_MAX=4 -> grants F,F,F,F,L,F,F,F,F,L...; enables never overlap.
//  5 Latency: MEM_LAT=3 -> mem_readEnable high 3 cycles, data sampled at E0+3; f_rdata unchanged by loader reads.
//  6 With IMEM_ARB_WPROT_EN, wp_lock=1: loader write addr 0 -> l_done=l_err=1 at E0+1, mem_writeEnable stays 0, memory unchanged.

Source files
------------

// File: rtl/imem_access_arbiter.sv
// rtl/imem_access_arbiter.sv - shares the instruction memory port between fetch and loader
// Optional write protection (wp_lock / l_err) is built when IMEM_ARB_WPROT_EN is defined.
module imem_access_arbiter #(
    parameter int unsigned ADDR_W     = 13,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic [31:0]       f_rdata,
    output logic              f_done,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [31:0]       l_wdata,
    output logic [31:0]       l_rdata,
    output logic              l_done,
`ifdef IMEM_ARB_WPROT_EN
    input  logic              wp_lock,
    output logic              l_err,
`endif
    output logic [31:0]       mem_address,
    output logic              mem_readEnable,
    output logic              mem_writeEnable,
    output logic [31:0]       mem_dataIn,
    input  logic [31:0]       mem_dataOut,
    output logic              busy
);

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);
    localparam int unsigned LW = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [LW-1:0]     cnt_q, cnt_d;
    logic              gnt_l_q, gnt_l_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              re_q, re_d;
    logic              we_q, we_d;
    logic [31:0]       din_q, din_d;
    logic [31:0]       f_rdata_q, f_rdata_d;
    logic [31:0]       l_rdata_q, l_rdata_d;
    logic              f_done_q, f_done_d;
    logic              l_done_q, l_done_d;
    logic              busy_q, busy_d;
`ifdef IMEM_ARB_WPROT_EN
    logic              prot_q, prot_d;
    logic              l_err_q, l_err_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            starve_q  <= '0;
            cnt_q     <= '0;
            gnt_l_q   <= 1'b0;
            addr_q    <= '0;
            re_q      <= 1'b0;
            we_q      <= 1'b0;
            din_q     <= '0;
            f_rdata_q <= '0;
            l_rdata_q <= '0;
            f_done_q  <= 1'b0;
            l_done_q  <= 1'b0;
            busy_q    <= 1'b0;
`ifdef IMEM_ARB_WPROT_EN
            prot_q    <= 1'b0;
            l_err_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            cnt_q     <= cnt_d;
            gnt_l_q   <= gnt_l_d;
            addr_q    <= addr_d;
            re_q      <= re_d;
            we_q      <= we_d;
            din_q     <= din_d;
            f_rdata_q <= f_rdata_d;
            l_rdata_q <= l_rdata_d;
            f_done_q  <= f_done_d;
            l_done_q  <= l_done_d;
            busy_q    <= busy_d;
`ifdef IMEM_ARB_WPROT_EN
            prot_q    <= prot_d;
            l_err_q   <= l_err_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        cnt_d     = cnt_q;
        gnt_l_d   = gnt_l_q;
        addr_d    = addr_q;
        re_d      = re_q;
        we_d      = we_q;
        din_d     = din_q;
        f_rdata_d = f_rdata_q;
        l_rdata_d = l_rdata_q;
        f_done_d  = 1'b0;
        l_done_d  = 1'b0;
`ifdef IMEM_ARB_WPROT_EN
        prot_d    = prot_q;
        l_err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // fetch wins unless the loader has already lost STARVE_MAX contended rounds
                if (f_req && (!l_req || (starve_q < SW'(STARVE_MAX)))) begin
                    state_d = READ;
                    re_d    = 1'b1;
                    gnt_l_d = 1'b0;
                    addr_d  = f_addr;
                    if (l_req) begin
                        starve_d = starve_q + 1'b1;
                    end
                end else if (l_req) begin
                    gnt_l_d  = 1'b1;
                    starve_d = '0;
                    addr_d   = l_addr;
                    if (l_we) begin
                        state_d = WRITE;
                        din_d   = l_wdata;
`ifdef IMEM_ARB_WPROT_EN
                        prot_d  = wp_lock;
                        we_d    = !wp_lock;
`else
                        we_d    = 1'b1;
`endif
                    end else begin
                        state_d = READ;
                        re_d    = 1'b1;
                    end
                end
            end
            READ: begin
                if (cnt_q == LW'(MEM_LAT - 1)) begin
                    re_d    = 1'b0;
                    state_d = DONE;
                    if (gnt_l_q) begin
                        l_rdata_d = mem_dataOut;
                        l_done_d  = 1'b1;
                    end else begin
                        f_rdata_d = mem_dataOut;
                        f_done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WRITE: begin
                we_d     = 1'b0;
                l_done_d = 1'b1;
                state_d  = DONE;
`ifdef IMEM_ARB_WPROT_EN
                l_err_d  = prot_q;
                prot_d   = 1'b0;
`endif
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign mem_address     = {{(32 - ADDR_W){1'b0}}, addr_q};
    assign mem_readEnable  = re_q;
    assign mem_writeEnable = we_q;
    assign mem_dataIn      = din_q;
    assign f_rdata         = f_rdata_q;
    assign l_rdata         = l_rdata_q;
    assign f_done          = f_done_q;
    assign l_done          = l_done_q;
    assign busy            = busy_q;
`ifdef IMEM_ARB_WPROT_EN
    assign l_err           = l_err_q;
`endif

endmodule
